// File: rtl/overdrive_pkg.sv
// Shared types and helpers for the multimode overdrive stage.
//   mode_e        : clip curve selector (BYPASS/HARD/SOFT/ASYM)
//   fade_state_e  : click-free mode-change sequencer states
//   GAIN_FRAC     : fractional bits of the Q4.4 drive gain
//   LEVEL_FRAC    : fractional bits of the Q1.7 output level
//   saturate()    : clamp a wide signed value into a w-bit signed range
package overdrive_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        HARD   = 2'd1,
        SOFT   = 2'd2,
        ASYM   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    localparam int GAIN_FRAC  = 4;
    localparam int LEVEL_FRAC = 7;

    // Callers cast the result down to their own sample width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/overdrive_fade_ctrl.sv
// Fade sequencer for click-free mode changes.
//   clk, rst    : clock, async active-high reset
//   in_valid    : accepted-sample strobe; the FSM only moves on samples
//   mode_in     : requested clip mode
//   fade        : current fade gain, 0..2**FADE_W
//   active_mode : mode currently applied to the datapath
//   fading      : high whenever the sequencer is not in RUN
module overdrive_fade_ctrl
    import overdrive_pkg::*;
#(
    parameter int FADE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        mode_in,
    output logic [FADE_W:0]   fade,
    output mode_e             active_mode,
    output logic              fading
);

    localparam logic [FADE_W:0] FULL = (FADE_W + 1)'(1) << FADE_W;

    fade_state_e     state;
    mode_e           req;
    logic            go_down;
    logic [FADE_W:0] dec;
    logic [FADE_W:0] inc;

    // A mismatch caught during FADE_IN ramps down from wherever the fade is;
    // at fade 0 the swap happens at once instead of underflowing.
    always_comb begin
        req     = mode_e'(mode_in);
        go_down = (state == FADE_OUT) || (req != active_mode);
        dec     = (fade == '0) ? '0 : fade - 1'b1;
        inc     = fade + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fade        <= FULL;
            active_mode <= BYPASS;
            fading      <= 1'b0;
        end else if (in_valid) begin
            if (go_down) begin
                fade   <= dec;
                fading <= 1'b1;
                if (dec == '0) begin
                    active_mode <= req;
                    state       <= FADE_IN;
                end else begin
                    state <= FADE_OUT;
                end
            end else if (state == FADE_IN) begin
                fade <= inc;
                if (inc == FULL) begin
                    state  <= RUN;
                    fading <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/softclip_lut.sv
// Combinational soft-clip curve, odd-symmetric.
//   x : signed input sample
//   y : shaped output; unity below CLIP_LEVEL/2, slope 1/4 above it,
//       never exceeding CLIP_LEVEL in magnitude.
module softclip_lut #(
    parameter int width      = 24,
    parameter int CLIP_LEVEL = 2 ** (width - 2)
) (
    input  logic signed [width-1:0] x,
    output logic signed [width-1:0] y
);

    localparam logic [width:0] KNEE = (width + 1)'(CLIP_LEVEL / 2);
    localparam logic [width:0] CLIP = (width + 1)'(CLIP_LEVEL);

    logic [width:0] mag;
    logic [width:0] shaped;

    // NOTE: every variable gets a default at the top of a combinational
    // block so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        mag    = x[width-1] ? (~{x[width-1], x} + 1'b1) : {1'b0, x};
        shaped = mag;
        if (mag > KNEE) begin
            shaped = KNEE + ((mag - KNEE) >> 2);
        end
        if (shaped > CLIP) begin
            shaped = CLIP;
        end
        y = x[width-1] ? -$signed(shaped[width-1:0]) : $signed(shaped[width-1:0]);
    end

endmodule

// File: rtl/overdrive_multimode.sv
// Multimode overdrive: drive gain, selectable clip curve, output level and
// a per-sample fade, in a valid-qualified pipeline (input capture + gain,
// shape, level, fade). A sample accepted at edge N appears after edge N+4.
//   clk, rst    : clock, async active-high reset
//   in_valid    : sample strobe, no backpressure
//   in_signal   : signed input sample
//   mode_in     : requested mode (0 BYPASS, 1 HARD, 2 SOFT, 3 ASYM)
//   drive       : Q4.4 pre-clip gain, sampled with each accepted sample
//   level       : Q1.7 output level, sampled with each accepted sample
//   out_valid   : output strobe
//   out_signal  : signed output sample
//   active_mode : mode currently applied
//   fading      : high during a mode-change ramp
module overdrive_multimode
    import overdrive_pkg::*;
#(
    parameter int width      = 24,
    parameter int GAIN_W     = 8,
    parameter int LEVEL_W    = 8,
    parameter int FADE_W     = 6,
    parameter int CLIP_LEVEL = 2 ** (width - 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [width-1:0] in_signal,
    input  logic [1:0]              mode_in,
    input  logic [GAIN_W-1:0]       drive,
    input  logic [LEVEL_W-1:0]      level,
    output logic                    out_valid,
    output logic signed [width-1:0] out_signal,
    output logic [1:0]              active_mode,
    output logic                    fading
);

    localparam logic signed [width-1:0] CLIP_POS = width'(CLIP_LEVEL);
    localparam logic signed [width-1:0] CLIP_NEG = -CLIP_POS;

    mode_e           cur_mode;
    logic [FADE_W:0] cur_fade;

    overdrive_fade_ctrl #(.FADE_W(FADE_W)) u_fade (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .mode_in     (mode_in),
        .fade        (cur_fade),
        .active_mode (cur_mode),
        .fading      (fading)
    );

    assign active_mode = cur_mode;

    // Each sample carries its own mode, fade and level down the pipe.
    logic                    v0, v1, v2, v3;
    logic signed [width-1:0] s0_x, s1_x, s1_p, s2_y, s3_y;
    logic [GAIN_W-1:0]       s0_drive;
    logic [LEVEL_W-1:0]      s0_level, s1_level, s2_level;
    mode_e                   s0_mode, s1_mode;
    logic [FADE_W:0]         s0_fade, s1_fade, s2_fade, s3_fade;

    logic signed [63:0]      x64, p64, y2_64, y3_64;
    logic signed [width-1:0] gain_y, shape_y, level_y, fade_y, soft_y;

    softclip_lut #(.width(width), .CLIP_LEVEL(CLIP_LEVEL)) u_soft (
        .x (s1_p),
        .y (soft_y)
    );

    // Signed >>> on the full-width products truncates toward -inf.
    always_comb begin
        x64    = s0_x;
        gain_y = width'(saturate((x64 * $signed(64'(s0_drive))) >>> GAIN_FRAC, width));

        p64     = s1_p;
        shape_y = s1_x;
        unique case (s1_mode)
            BYPASS: shape_y = s1_x;
            HARD:   shape_y = (s1_p > CLIP_POS) ? CLIP_POS :
                              (s1_p < CLIP_NEG) ? CLIP_NEG : s1_p;
            SOFT:   shape_y = soft_y;
            ASYM:   shape_y = (p64 >= 0) ? soft_y :
                              (s1_p < CLIP_NEG) ? CLIP_NEG : s1_p;
            default: shape_y = s1_x;
        endcase

        y2_64   = s2_y;
        level_y = width'(saturate((y2_64 * $signed(64'(s2_level))) >>> LEVEL_FRAC, width));

        // fade <= 2**FADE_W, so the scaled value never grows in magnitude.
        y3_64  = s3_y;
        fade_y = width'((y3_64 * $signed(64'(s3_fade))) >>> FADE_W);
    end

    // NOTE: the datapath registers are reset along with the valids so a
    // reset leaves no stale sample anywhere in the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v0, v1, v2, v3} <= '0;
            s0_x       <= '0;
            s0_drive   <= '0;
            s0_level   <= '0;
            s0_mode    <= BYPASS;
            s0_fade    <= '0;
            s1_x       <= '0;
            s1_p       <= '0;
            s1_level   <= '0;
            s1_mode    <= BYPASS;
            s1_fade    <= '0;
            s2_y       <= '0;
            s2_level   <= '0;
            s2_fade    <= '0;
            s3_y       <= '0;
            s3_fade    <= '0;
            out_signal <= '0;
            out_valid  <= 1'b0;
        end else begin
            v0       <= in_valid;
            s0_x     <= in_signal;
            s0_drive <= drive;
            s0_level <= level;
            s0_mode  <= cur_mode;
            s0_fade  <= cur_fade;

            v1       <= v0;
            s1_x     <= s0_x;
            s1_p     <= gain_y;
            s1_level <= s0_level;
            s1_mode  <= s0_mode;
            s1_fade  <= s0_fade;

            v2       <= v1;
            s2_y     <= shape_y;
            s2_level <= s1_level;
            s2_fade  <= s1_fade;

            v3       <= v2;
            s3_y     <= level_y;
            s3_fade  <= s2_fade;

            out_valid  <= v3;
            out_signal <= fade_y;
        end
    end

endmodule

// File: tb/tb_overdrive_multimode.sv
// Directed bench for overdrive_multimode with width=24, FADE_W=3,
// CLIP_LEVEL=2097152. Expected outputs are hand-computed constants queued
// per sample and compared in order as out_valid strobes arrive.
module tb_overdrive_multimode;
    import overdrive_pkg::*;

    localparam int W  = 24;
    localparam int FW = 3;
    localparam int CL = 2097152;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] in_signal;
    logic [1:0]          mode_in;
    logic [7:0]          drive;
    logic [7:0]          level;
    logic                out_valid;
    logic signed [W-1:0] out_signal;
    logic [1:0]          active_mode;
    logic                fading;

    overdrive_multimode #(
        .width(W), .GAIN_W(8), .LEVEL_W(8), .FADE_W(FW), .CLIP_LEVEL(CL)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_signal(in_signal),
        .mode_in(mode_in), .drive(drive), .level(level),
        .out_valid(out_valid), .out_signal(out_signal),
        .active_mode(active_mode), .fading(fading)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    exp_q[$];
    string tag_q[$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Output monitor: compares each strobed sample with the queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check(tag_q.pop_front(), out_signal, exp_q.pop_front());
            end
        end
    end

    // One accepted sample; optionally checks the FSM outputs seen by it.
    task automatic send(input logic [1:0] m, input int d, input int l,
                        input int x, input int e, input string tag,
                        input bit chk_fsm, input bit exp_fading, input int exp_mode);
        @(negedge clk);
        mode_in   = m;
        drive     = 8'(d);
        level     = 8'(l);
        in_signal = W'(x);
        in_valid  = 1'b1;
        if (chk_fsm) begin
            check({tag, "_fading"}, fading, exp_fading);
            check({tag, "_active_mode"}, active_mode, exp_mode);
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            check({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
            tag_q.delete();
        end
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        tag_q.delete();
        idle(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Zero-input samples until any mode change has fully faded back in.
    task automatic settle(input logic [1:0] m);
        for (int i = 0; i < 18; i++) send(m, 16, 128, 0, 0, "settle", 1'b0, 1'b0, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        int         drive;
        int         level;
        int         x;
        int         exp;
        string      name;
    } vec_t;

    vec_t vecs[17];
    int   fade_exp[17];
    int   swap_exp[24];

    initial begin
        vecs[0]  = '{2'd0,  16, 128,  1234567,  1234567, "bypass_unity"};
        vecs[1]  = '{2'd1,  16, 128,  3000000,  2097152, "hard_pos_clip"};
        vecs[2]  = '{2'd1,  16, 128, -3000000, -2097152, "hard_neg_clip"};
        vecs[3]  = '{2'd1,  16, 128,  1000000,  1000000, "hard_linear"};
        vecs[4]  = '{2'd1, 255, 128,  8388607,  2097152, "hard_gain_sat"};
        vecs[5]  = '{2'd3, 255, 128, -8388608, -2097152, "asym_neg_sat"};
        vecs[6]  = '{2'd1,  16,  64,  1000000,   500000, "hard_half_level"};
        vecs[7]  = '{2'd2,  16, 128,  3000000,  1536432, "soft_pos"};
        vecs[8]  = '{2'd2,  16, 128, -3000000, -1536432, "soft_neg"};
        vecs[9]  = '{2'd2,  16, 128,   500000,   500000, "soft_below_knee"};
        vecs[10] = '{2'd3,  16, 128,  3000000,  1536432, "asym_pos_soft"};
        vecs[11] = '{2'd3,  16, 128, -1000000, -1000000, "asym_neg_linear"};
        vecs[12] = '{2'd0, 255, 128,     1000,     1000, "bypass_pre_gain"};
        vecs[13] = '{2'd0,  16, 255,  8000000,  8388607, "bypass_level_sat"};
        vecs[14] = '{2'd1,  16,  64, -1000001,  -500001, "level_floor"};
        vecs[15] = '{2'd1,   8, 128,       -3,       -2, "gain_floor"};
        vecs[16] = '{2'd2,  32, 128,  1500000,  1536432, "soft_drive2"};

        fade_exp = '{3000000, 2625000, 2250000, 1875000, 1500000, 1125000, 750000, 375000,
                     0, 262144, 524288, 786432, 1048576, 1310720, 1572864, 1835008, 2097152};

        swap_exp = '{3000000, 2625000, 2250000, 1875000, 1500000, 1125000, 750000, 375000,
                     0, 262144, 524288, 786432, 524288, 262144,
                     0, 192054, 384108, 576162, 768216, 960270, 1152324, 1344378,
                     1536432, 1536432};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signal = '0;
        mode_in   = 2'd0;
        drive     = 8'd16;
        level     = 8'd128;
        #12;
        check("reset_out_signal", out_signal, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_active_mode", active_mode, 0);
        check("reset_fading", fading, 0);
        @(negedge clk);
        rst = 1'b0;

        // BYPASS stream, then reset while outputs are in flight.
        for (int i = 0; i < 6; i++) send(2'd0, 16, 128, 1234567, 1234567, "bypass_stream", 1'b0, 1'b0, 0);
        #2;
        check("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("midstream_reset_out_valid", out_valid, 0);
        check("midstream_reset_out_signal", out_signal, 0);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // Reset in the middle of a fade returns the sequencer to RUN/BYPASS.
        for (int i = 0; i < 3; i++) send(2'd1, 16, 128, 3000000, fade_exp[i], "prefade", 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midfade_reset_fading", fading, 0);
        check("midfade_reset_active_mode", active_mode, 0);
        exp_q.delete();
        tag_q.delete();
        idle(2);
        @(negedge clk);
        rst = 1'b0;

        // Table of settled single-sample vectors.
        for (int v = 0; v < 17; v++) begin
            settle(vecs[v].mode);
            send(vecs[v].mode, vecs[v].drive, vecs[v].level, vecs[v].x, vecs[v].exp,
                 vecs[v].name, 1'b1, 1'b0, int'(vecs[v].mode));
            drain(vecs[v].name);
        end

        // Fade BYPASS -> HARD, one sample per cycle.
        do_reset();
        for (int k = 0; k < 17; k++)
            send(2'd1, 16, 128, 3000000, fade_exp[k], $sformatf("fade_s%0d", k),
                 1'b1, (k >= 1 && k <= 15), (k >= 8) ? 1 : 0);
        drain("fade");

        // Same fade with one sample every five cycles.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send(2'd1, 16, 128, 3000000, fade_exp[k], $sformatf("sparse_s%0d", k),
                 1'b1, (k >= 1 && k <= 15), (k >= 8) ? 1 : 0);
            idle(4);
        end
        drain("sparse");

        // Retarget to SOFT while fading in at f=3.
        do_reset();
        for (int k = 0; k < 24; k++)
            send((k >= 11) ? 2'd2 : 2'd1, 16, 128, 3000000, swap_exp[k],
                 $sformatf("retarget_s%0d", k), 1'b1, (k >= 1 && k <= 21),
                 (k >= 14) ? 2 : ((k >= 8) ? 1 : 0));
        drain("retarget");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overdrive_multimode.md
Name: overdrive_multimode

Overview:
- Parametrised next-generation overdrive stage that sits in the effects chain between input conditioning and the next creator block.
- Adds four runtime-selectable clip modes, pre-clip drive gain, post-clip output level, and a valid-qualified 4-stage pipeline.
- Mode changes are click-free: the block fades out, swaps the curve at silence, then fades back in.
- Reuses the existing combinational softclip_lut for the soft curve.

Parameters:
- width, 24, sample width (signed two's complement).
- GAIN_W, 8, drive width; unsigned Q4.4, 16 = unity.
- LEVEL_W, 8, output level width; unsigned Q1.7, 128 = unity.
- FADE_W, 6, fade resolution; full scale = 2**FADE_W samples per ramp.
- CLIP_LEVEL, 2**(width-2), hard-clip threshold magnitude.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample strobe; no backpressure
- in_signal  in  width  signed input sample
- mode_in  in  2  requested mode: 0 BYPASS, 1 HARD, 2 SOFT, 3 ASYM
- drive  in  GAIN_W  pre-clip gain, sampled with each accepted sample
- level  in  LEVEL_W  output level, sampled with each accepted sample
- out_valid  out  1  output strobe
- out_signal  out  width  signed output sample
- active_mode  out  2  mode currently applied
- fading  out  1  high while in FADE_OUT or FADE_IN

Behaviour:
- Reset (async, all registers):
  - out_signal = 0, out_valid = 0, all pipeline valids = 0.
  - State RUN, fade = 2**FADE_W, active_mode = BYPASS, fading = 0.
  - Reset mid-fade or mid-pipeline discards everything in flight.
- Pipeline: sample accepted at edge N (in_valid=1) → out_valid=1 with its result after edge N+4. Each sample carries its own mode, fade, drive and level values through the pipe. Throughput is one sample per clk.
- Stage 1, gain:
  - p = in_signal * drive, full-width signed product, arithmetic shift right by 4.
  - Saturate to [-2**(width-1), 2**(width-1)-1].
- Stage 2, shape:
  - BYPASS: passes the raw in_signal, pre-gain.
  - HARD: clamp to [-CLIP_LEVEL, CLIP_LEVEL].
  - SOFT: softclip_lut(p).
  - ASYM: p ≥ 0 → softclip_lut(p); p < 0 → max(p, -CLIP_LEVEL).
- Stage 3, level: y * level, arithmetic shift right by 7, saturate to width.
- Stage 4, fade: y * f, arithmetic shift right by FADE_W, with f in 0..2**FADE_W.
- Rounding: all shifts truncate toward −∞; no rounding bias.
- Fade FSM updates only on accepted samples. Each sample uses the fade and active_mode values present before that edge's update.
  - RUN: if mode_in ≠ active_mode → FADE_OUT and fade −1. Otherwise hold.
  - FADE_OUT: fade −1 per sample. On the sample where fade becomes 0, active_mode ← mode_in (value at that edge) and state → FADE_IN.
  - FADE_IN: fade +1 per sample. When fade reaches 2**FADE_W → RUN.
  - FADE_OUT boundary: a mode_in change, or a return to the old mode, does not abort the ramp. The ramp completes and the swap uses mode_in at the swap edge. A swap to the same mode still fades in.
  - FADE_IN boundary: if mode_in ≠ active_mode → FADE_OUT, decrementing from the current fade value.
  - No new sample → FSM holds state.
- fading = (state ≠ RUN), registered.
- drive and level are not faded; changes apply from the next accepted sample.

Decomposition:
- overdrive_pkg holds:
  - mode_e enum (BYPASS/HARD/SOFT/ASYM, 2-bit).
  - fade_state_e enum (RUN/FADE_OUT/FADE_IN).
  - Q-format shift constants: GAIN_FRAC = 4, LEVEL_FRAC = 7.
  - A saturate function.
- One natural sub-module: overdrive_fade_ctrl. It owns the FSM, the fade counter and active_mode; its inputs are in_valid and mode_in. The datapath stays in overdrive_multimode.

Test Plan (width=24, FADE_W=3, CLIP_LEVEL=2097152, drive=16, level=128 unless stated):
- Reset then BYPASS, in=1234567 valid every cycle → out_valid 4 cycles later with out=1234567; assert rst mid-stream → out_signal and out_valid go to 0 immediately, with no stale outputs afterwards.
- Mode HARD with FSM settled in RUN, in=3000000 → out=2097152; in=-3000000 → out=-2097152; in=1000000 → out=1000000.
- Gain saturation, HARD: drive=255, in=8388607 → stage 1 = 8388607, out=2097152; ASYM with in=-8388608 → out=-2097152. Level: drive=16, level=64, HARD, in=1000000 → out=500000.
- Fade BYPASS→HARD, constant in=3000000, mode_in=HARD from sample 0:
  - Outputs 3000000, 2625000, 2250000, 1875000, 1500000, 1125000, 750000, 375000.
  - Then 0, 262144, 524288, 786432, 1048576, 1310720, 1572864, 1835008.
  - Then steady 2097152; fading high exactly for samples 1–15; active_mode=HARD from sample 8.
- Sparse in_valid (1 in 5 cycles) during a fade → same output sequence as the previous scenario; FSM and fade do not advance on idle cycles.
- During FADE_IN at f=3, change mode_in to SOFT → next samples use f=3, 2, 1, then swap to SOFT, then f=0…8.
